// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module     : alu_multicycle
// Description: Width-parametrised registered ALU. Single-cycle arithmetic and
//              logic ops, iterative one-bit-per-cycle shifts and an optional
//              iterative shift-add multiply, behind a start/ready/done
//              handshake. Owns the registered C/L/F/Z/N status flags.
//              Optional feature macro: ALU_MULTIPLY_EN (opcode 8 = MUL).
// Revision   : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             low,
  output logic             flag,
  output logic             zero,
  output logic             negative
);

  // Signed shift amount width; also wide enough to count WIDTH multiply steps.
  localparam int SHIFT_BITS = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_LSH = 4'd6;
  localparam logic [3:0] OP_ASH = 4'd7;
`ifdef ALU_MULTIPLY_EN
  localparam logic [3:0] OP_MUL = 4'd8;
  // The accept edge performs step 0, the MULT state the remaining WIDTH-1.
  localparam logic [SHIFT_BITS-1:0] MUL_STEPS = SHIFT_BITS'(WIDTH - 1);
`endif

`ifdef ALU_MULTIPLY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MULT  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t state, state_next;

  // Iteration registers: the partially shifted operand and remaining steps.
  logic [WIDTH-1:0]      work, work_next;
  logic [SHIFT_BITS-1:0] count, count_next;
  logic                  shift_left, shift_left_next;
  logic                  shift_arith, shift_arith_next;

`ifdef ALU_MULTIPLY_EN
  // Shift-add multiplier: accumulator, shifted multiplicand, consumed multiplier.
  logic [WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0] mcand, mcand_next;
  logic [WIDTH-1:0] mplier, mplier_next;
  logic [WIDTH-1:0] acc_step;
`endif

  // Completion strobe and the values committed to the output registers.
  logic             fin;
  logic [WIDTH-1:0] fin_result;
  logic [4:0]       fin_flags;

  logic [SHIFT_BITS-1:0] shift_amt;
  logic [SHIFT_BITS-1:0] shift_mag;
  logic                  shift_left_in;
  logic                  shift_arith_in;
  logic [WIDTH-1:0]      first_step;
  logic [WIDTH-1:0]      work_step;
  logic [WIDTH+4:0]      single;

  // One bit of shift: left fills 0, right fills 0 or the sign bit.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                  input logic             left,
                                                  input logic             arith);
    if (left) begin
      return {v[WIDTH-2:0], 1'b0};
    end
    return {arith & v[WIDTH-1], v[WIDTH-1:1]};
  endfunction

  // Flag vector {C, L, F, Z, N} for ops that only report zero.
  function automatic logic [4:0] zero_only(input logic [WIDTH-1:0] v);
    return {3'b000, (v == '0), 1'b0};
  endfunction

  // Single-cycle ops, returned as {result, C, L, F, Z, N}. A shift reaching
  // this path has amount 0 and passes a through; illegal opcodes yield zeros.
  function automatic logic [WIDTH+4:0] single_cycle(input logic [3:0]       op,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] r;
    logic             c, l, f, z, n, legal;
    sum   = {1'b0, x} + {1'b0, y};
    diff  = x - y;
    r     = '0;
    c     = 1'b0;
    l     = 1'b0;
    f     = 1'b0;
    n     = 1'b0;
    legal = 1'b1;
    case (op)
      OP_ADD: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        f = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        r = diff;
        c = (x < y);
        f = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      OP_CMP: begin
        r = diff;
        l = (x < y);
        n = ($signed(x) < $signed(y));
      end
      OP_AND:         r = x & y;
      OP_OR:          r = x | y;
      OP_XOR:         r = x ^ y;
      OP_LSH, OP_ASH: r = x;
      default:        legal = 1'b0;
    endcase
    // CMP: a-b is zero exactly when a==b, so one zero test serves every op.
    z = legal && (r == '0);
    return {r, c, l, f, z, n};
  endfunction

  assign ready          = (state == IDLE);
  assign shift_amt      = b[SHIFT_BITS-1:0];
  assign shift_mag      = shift_amt[SHIFT_BITS-1] ? (SHIFT_BITS'(0) - shift_amt) : shift_amt;
  assign shift_left_in  = ~shift_amt[SHIFT_BITS-1];
  assign shift_arith_in = (operation == OP_ASH);
  assign first_step     = shift_step(a, shift_left_in, shift_arith_in);
  assign work_step      = shift_step(work, shift_left, shift_arith);
  assign single         = single_cycle(operation, a, b);

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, iteration updates and completion values.
  always_comb begin
    state_next       = state;
    work_next        = work;
    count_next       = count;
    shift_left_next  = shift_left;
    shift_arith_next = shift_arith;
`ifdef ALU_MULTIPLY_EN
    acc_next         = acc;
    mcand_next       = mcand;
    mplier_next      = mplier;
    acc_step         = acc + (mplier[0] ? mcand : '0);
`endif
    fin              = 1'b0;
    fin_result       = '0;
    fin_flags        = '0;

    case (state)
      IDLE: begin
        if (start) begin
          if ((operation == OP_LSH || operation == OP_ASH) && (shift_mag != '0)) begin
            // The accept edge already performs the first bit of the shift.
            if (shift_mag == SHIFT_BITS'(1)) begin
              fin        = 1'b1;
              fin_result = first_step;
              fin_flags  = zero_only(first_step);
            end else begin
              state_next       = SHIFT;
              work_next        = first_step;
              count_next       = shift_mag - SHIFT_BITS'(1);
              shift_left_next  = shift_left_in;
              shift_arith_next = shift_arith_in;
            end
          end
`ifdef ALU_MULTIPLY_EN
          else if (operation == OP_MUL) begin
            state_next  = MULT;
            acc_next    = b[0] ? a : '0;
            mcand_next  = a << 1;
            mplier_next = b >> 1;
            count_next  = MUL_STEPS;
          end
`endif
          else begin
            fin        = 1'b1;
            fin_result = single[WIDTH+4:5];
            fin_flags  = single[4:0];
          end
        end
      end

      SHIFT: begin
        if (count == SHIFT_BITS'(1)) begin
          state_next = IDLE;
          fin        = 1'b1;
          fin_result = work_step;
          fin_flags  = zero_only(work_step);
        end else begin
          work_next  = work_step;
          count_next = count - SHIFT_BITS'(1);
        end
      end

`ifdef ALU_MULTIPLY_EN
      MULT: begin
        if (count == SHIFT_BITS'(1)) begin
          state_next = IDLE;
          fin        = 1'b1;
          fin_result = acc_step;
          fin_flags  = zero_only(acc_step);
        end else begin
          acc_next    = acc_step;
          mcand_next  = mcand << 1;
          mplier_next = mplier >> 1;
          count_next  = count - SHIFT_BITS'(1);
        end
      end
`endif

      default: state_next = IDLE;
    endcase
  end

  // Iteration registers and the result/flag registers, which move only on done.
  always_ff @(posedge clock) begin
    if (reset) begin
      work        <= '0;
      count       <= '0;
      shift_left  <= 1'b0;
      shift_arith <= 1'b0;
`ifdef ALU_MULTIPLY_EN
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
`endif
      done        <= 1'b0;
      result      <= '0;
      carry       <= 1'b0;
      low         <= 1'b0;
      flag        <= 1'b0;
      zero        <= 1'b0;
      negative    <= 1'b0;
    end else begin
      work        <= work_next;
      count       <= count_next;
      shift_left  <= shift_left_next;
      shift_arith <= shift_arith_next;
`ifdef ALU_MULTIPLY_EN
      acc         <= acc_next;
      mcand       <= mcand_next;
      mplier      <= mplier_next;
`endif
      done        <= fin;
      if (fin) begin
        result                              <= fin_result;
        {carry, low, flag, zero, negative}  <= fin_flags;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : tb_alu_multicycle
// Description: Self-checking bench for alu_multicycle (WIDTH=16): directed
//              vector table, handshake corner sequences and random operations
//              against an arithmetic reference model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   operation = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, done, carry, low, flag, zero, negative;
  logic [W-1:0] result;

  int tests = 0;
  int fails = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .operation(operation),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .low      (low),
    .flag     (flag),
    .zero     (zero),
    .negative (negative)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Reference model: expected result, flags {C,L,F,Z,N} and done latency.
  function automatic void model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] r, output logic [4:0] f, output int lat);
    int sx, sy, sum, k, mag;
    logic signed [4:0] kraw;
    logic c, l, v, z, n, legal;
`ifdef ALU_MULTIPLY_EN
    longint p;
`endif
    sx    = int'($signed(x));
    sy    = int'($signed(y));
    kraw  = y[4:0];
    k     = int'(kraw);
    mag   = (k < 0) ? -k : k;
    r     = '0;
    c     = 1'b0;
    l     = 1'b0;
    v     = 1'b0;
    n     = 1'b0;
    legal = 1'b1;
    lat   = 1;
    case (op)
      4'd0: begin
        sum = int'(x) + int'(y);
        r   = sum[15:0];
        c   = (sum > 65535);
        v   = (sx + sy > 32767) || (sx + sy < -32768);
      end
      4'd1: begin
        r = x - y;
        c = (x < y);
        v = (sx - sy > 32767) || (sx - sy < -32768);
      end
      4'd2: begin
        r = x - y;
        l = (x < y);
        n = (sx < sy);
      end
      4'd3: r = x & y;
      4'd4: r = x | y;
      4'd5: r = x ^ y;
      4'd6: begin
        if (mag >= 16)   r = '0;
        else if (k >= 0) r = x << mag;
        else             r = x >> mag;
        lat = (mag == 0) ? 1 : mag;
      end
      4'd7: begin
        if (k >= 0)        r = (mag >= 16) ? 16'h0000 : 16'(x << mag);
        else if (mag >= 16) r = x[15] ? 16'hFFFF : 16'h0000;
        else               r = 16'(sx >>> mag);
        lat = (mag == 0) ? 1 : mag;
      end
`ifdef ALU_MULTIPLY_EN
      4'd8: begin
        p   = longint'(x) * longint'(y);
        r   = p[15:0];
        lat = 16;
      end
`endif
      default: legal = 1'b0;
    endcase
    z = legal && (r == 16'h0000);
    f = {c, l, v, z, n};
  endfunction

  // Issue one operation at a negedge with the DUT idle; wait (bounded) for done.
  // Inputs are scrambled while busy to show operands are latched at accept.
  task automatic run_op(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                        output int lat, output logic [15:0] r, output logic [4:0] f,
                        output int ready_busy);
    start      = 1'b1;
    operation  = op;
    a          = x;
    b          = y;
    lat        = 0;
    ready_busy = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      start     = 1'b0;
      operation = 4'($urandom);
      a         = 16'($urandom);
      b         = 16'($urandom);
      if (done) begin
        lat = i;
        break;
      end
      if (ready) ready_busy++;
    end
    r = result;
    f = {carry, low, flag, zero, negative};
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] r;
    logic [4:0]  f;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int          lat, rb, dones, first_done;
    logic [15:0] r, er;
    logic [4:0]  f, ef;
    int          elat;
    logic [3:0]  op;
    logic [15:0] x, y;

    // Directed vectors: {op, a, b, result, flags {C,L,F,Z,N}, latency}.
    vecs[0]  = '{4'd0, 16'h7FFF, 16'h0001, 16'h8000, 5'b00100, 1};
    vecs[1]  = '{4'd1, 16'h0000, 16'h0001, 16'hFFFF, 5'b10000, 1};
    vecs[2]  = '{4'd2, 16'hFFFF, 16'h0001, 16'hFFFE, 5'b00001, 1};
    vecs[3]  = '{4'd7, 16'h8010, 16'hFFFC, 16'hF801, 5'b00000, 4};
    vecs[4]  = '{4'd6, 16'h0001, 16'h0003, 16'h0008, 5'b00000, 3};
    vecs[5]  = '{4'd5, 16'h00FF, 16'h0F0F, 16'h0FF0, 5'b00000, 1};
`ifdef ALU_MULTIPLY_EN
    vecs[6]  = '{4'd8, 16'h0123, 16'h0010, 16'h1230, 5'b00000, 16};
`else
    vecs[6]  = '{4'd8, 16'h0123, 16'h0010, 16'h0000, 5'b00000, 1};
`endif
    vecs[7]  = '{4'd0, 16'hFFFF, 16'h0001, 16'h0000, 5'b10010, 1};
    vecs[8]  = '{4'd6, 16'h1234, 16'h0010, 16'h0000, 5'b00010, 16};
    vecs[9]  = '{4'd7, 16'h8000, 16'h0010, 16'hFFFF, 5'b00000, 16};
    vecs[10] = '{4'd15, 16'h1234, 16'h0001, 16'h0000, 5'b00000, 1};
    vecs[11] = '{4'd6, 16'h00A5, 16'h0000, 16'h00A5, 5'b00000, 1};
    vecs[12] = '{4'd2, 16'h0001, 16'hFFFF, 16'h0002, 5'b01000, 1};
    vecs[13] = '{4'd1, 16'h8000, 16'h0001, 16'h7FFF, 5'b00100, 1};

    // Reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset ready", 32'(ready), 32'd1);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset flags", 32'({carry, low, flag, zero, negative}), 32'd0);

    // Directed table; each op starts in the previous done cycle (back-to-back).
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].x, vecs[i].y, lat, r, f, rb);
      check($sformatf("vec%0d result", i), 32'(r), 32'(vecs[i].r));
      check($sformatf("vec%0d flags", i), 32'(f), 32'(vecs[i].f));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d ready while busy", i), 32'(rb), 32'd0);
    end

    // Start held high while busy: only the first request is accepted.
    @(negedge clock);
    start     = 1'b1;
    operation = 4'd6;
    a         = 16'h0001;
    b         = 16'h0008;
    dones      = 0;
    first_done = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (done) begin
        dones++;
        if (first_done == 0) begin
          first_done = i;
          check("busy-start result", 32'(result), 32'h0100);
        end
      end
      start     = (dones == 0);
      operation = 4'd5;
      a         = 16'($urandom);
      b         = 16'($urandom);
    end
    check("busy-start done latency", 32'(first_done), 32'd8);
    check("busy-start done count", 32'(dones), 32'd1);

    // Reset mid-operation: outputs cleared, no done pulse, idle next cycle.
    run_op(4'd2, 16'h0001, 16'hFFFF, lat, r, f, rb);
    check("pre-reset result", 32'(r), 32'h0002);
    start = 1'b1;
`ifdef ALU_MULTIPLY_EN
    operation = 4'd8;
    a         = 16'h0003;
    b         = 16'h0005;
`else
    operation = 4'd7;
    a         = 16'h8000;
    b         = 16'h0016;
`endif
    dones = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) dones++;
      if (i == 5) reset = 1'b1;
    end
    @(negedge clock);
    reset = 1'b0;
    check("mid-reset done", 32'(done), 32'd0);
    check("mid-reset result", 32'(result), 32'd0);
    check("mid-reset flags", 32'({carry, low, flag, zero, negative}), 32'd0);
    check("mid-reset ready", 32'(ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("mid-reset no done", 32'(dones), 32'd0);
    run_op(4'd5, 16'h00FF, 16'h0F0F, lat, r, f, rb);
    check("post-reset result", 32'(r), 32'h0FF0);
    check("post-reset latency", 32'(lat), 32'd1);

    // Random operations against the reference model.
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      x  = 16'($urandom);
      y  = 16'($urandom);
      if (i % 4 == 0) x = (i % 8 == 0) ? 16'h8000 : 16'h7FFF;
      model(op, x, y, er, ef, elat);
      run_op(op, x, y, lat, r, f, rb);
      check($sformatf("rand%0d op%0d result", i, op), 32'(r), 32'(er));
      check($sformatf("rand%0d op%0d flags", i, op), 32'(f), 32'(ef));
      check($sformatf("rand%0d op%0d latency", i, op), 32'(lat), 32'(elat));
      if (rb != 0) check($sformatf("rand%0d ready while busy", i), 32'(rb), 32'd0);
    end

    // done is a one-cycle pulse when no further request follows.
    @(negedge clock);
    check("done pulse width", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
